// File: rtl/rom_loader_pkg.sv
// Shared definitions for the ROM loader: the download region table, its
// entry type and the loader FSM state encoding.
//   REGION_TABLE : per-region ioctl index, SDRAM byte base and byte size
//   state_t      : loader FSM states
package loader_pkg;

  localparam int LOADER_AW      = 25;
  localparam int LOADER_REGIONS = 4;

  typedef struct packed {
    logic [5:0]           index;
    logic [LOADER_AW-1:0] base;
    logic [LOADER_AW-1:0] size;
  } region_t;

  // Lower entries win when two entries share an index.
  localparam region_t REGION_TABLE [LOADER_REGIONS] = '{
    '{index: 6'd0, base: 25'h000000, size: 25'h100000},
    '{index: 6'd1, base: 25'h100000, size: 25'h000010},
    '{index: 6'd2, base: 25'h200000, size: 25'h100000},
    '{index: 6'd3, base: 25'h300000, size: 25'h001000}
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/rom_loader_if.sv
// Bus bundle between hps_io download port, the loader and the SDRAM
// write port.
//   ioctl_*          : HPS download stream (ioctl_wait is flow control back)
//   mem_addr/mem_din : SDRAM write address/data, held while a request pends
//   mem_req/mem_ack  : toggle handshake; pending while they differ
// modport slave  : the loader
// modport master : the environment (hps_io + sdram controller)
interface rom_loader_if #(
  parameter int DW = 16,
  parameter int AW = 25
);
  logic          ioctl_download;
  logic [7:0]    ioctl_index;
  logic          ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [DW-1:0] ioctl_dout;
  logic          ioctl_wait;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_req;
  logic          mem_ack;

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ack,
    output ioctl_wait, mem_addr, mem_din, mem_req
  );

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ack,
    input  ioctl_wait, mem_addr, mem_din, mem_req
  );
endinterface

// File: rtl/loader_fifo.sv
// Small synchronous write buffer for the ROM loader.
//   push/din   : write an entry (accepted when not full, or full with pop)
//   pop/dout   : dout shows the head; pop removes it when not empty
//   full/empty : occupancy flags
//   count      : current number of entries
module loader_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  // A simultaneous pop frees the head slot, so a full FIFO still takes the push.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/rom_loader.sv
// Streams an HPS ioctl download into SDRAM for one of several regions.
// The region is chosen from ioctl_index on the rising edge of
// ioctl_download; each write is offset by the region base, buffered, and
// issued to SDRAM over a toggle req/ack handshake, one request at a time.
//   clk_sys, reset : clock and synchronous active-high reset
//   bus            : ioctl stream + SDRAM write port (rom_loader_if.slave)
//   busy           : loading or draining
//   done           : one-cycle pulse when a load completes
//   region_active  : one-hot active region, zero when idle
//   overflow       : sticky; a write was out of range or hit a full buffer
module rom_loader
  import loader_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int DW          = 16,
  parameter int AW          = 25,
  parameter int FIFO_DEPTH  = 4,
  parameter int SWAP_BYTES  = 0
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  rom_loader_if.slave            bus,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_REGIONS-1:0] region_active,
  output logic                   overflow
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = AW + DW;
  localparam logic [CW-1:0] WAIT_AT = CW'(FIFO_DEPTH - 1);

  function automatic logic [DW-1:0] fmt_data(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    if (SWAP_BYTES != 0 && DW == 16) begin
      for (int b = 0; b < DW/8; b++) r[8*b +: 8] = d[DW-8-8*b +: 8];
    end
    return r;
  endfunction

  state_t                 st;
  logic                   dl_q;
  logic                   rise_pend;
  logic [AW-1:0]          base;
  logic [AW-1:0]          size;
  logic                   hit;
  logic [NUM_REGIONS-1:0] sel;
  logic [AW-1:0]          sel_base;
  logic [AW-1:0]          sel_size;
  logic                   rise;
  logic                   fall;
  logic                   start;
  logic [AW-1:0]          addr_aw;
  logic                   in_range;
  logic                   req_idle;
  logic                   push;
  logic                   pop;
  logic                   drop;
  logic [EW-1:0]          head;
  logic                   full;
  logic                   empty;
  logic [CW-1:0]          cnt;
  logic                   unused_idx;

  assign unused_idx = &{1'b0, bus.ioctl_index[7:6]};

  // Scan downwards so the lowest matching entry is the one left selected.
  always_comb begin
    hit      = 1'b0;
    sel      = '0;
    sel_base = '0;
    sel_size = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (bus.ioctl_index[5:0] == REGION_TABLE[i].index) begin
        hit      = 1'b1;
        sel      = '0;
        sel[i]   = 1'b1;
        sel_base = AW'(REGION_TABLE[i].base);
        sel_size = AW'(REGION_TABLE[i].size);
      end
    end
  end

  assign rise     = bus.ioctl_download & ~dl_q;
  assign fall     = ~bus.ioctl_download & dl_q;
  assign start    = (st == ST_IDLE) & (rise | rise_pend) & hit;
  assign addr_aw  = AW'(bus.ioctl_addr);
  assign in_range = addr_aw < size;
  assign req_idle = (bus.mem_req == bus.mem_ack);
  assign pop      = req_idle & ~empty;
  assign push     = (st == ST_LOAD) & bus.ioctl_wr & in_range & (~full | pop);
  assign drop     = (st == ST_LOAD) & bus.ioctl_wr & ~(in_range & (~full | pop));

  loader_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_sys),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .din   ({base + addr_aw, fmt_data(bus.ioctl_dout)}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (cnt)
  );

  always_ff @(posedge clk_sys) begin
    if (start) begin
      base <= sel_base;
      size <= sel_size;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      st             <= ST_IDLE;
      // Seeding with the live level avoids treating a download that is
      // still high across reset as a fresh start.
      dl_q           <= bus.ioctl_download;
      rise_pend      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      region_active  <= '0;
      overflow       <= 1'b0;
      bus.ioctl_wait <= 1'b0;
      bus.mem_req    <= bus.mem_ack;
      bus.mem_addr   <= '0;
      bus.mem_din    <= '0;
    end else begin
      dl_q           <= bus.ioctl_download;
      done           <= 1'b0;
      bus.ioctl_wait <= (cnt >= WAIT_AT);

      if (pop) begin
        bus.mem_addr <= head[EW-1:DW];
        bus.mem_din  <= head[DW-1:0];
        bus.mem_req  <= ~bus.mem_req;
      end

      if (drop) overflow <= 1'b1;
      if (rise && st != ST_IDLE) rise_pend <= 1'b1;

      case (st)
        ST_IDLE: begin
          rise_pend <= 1'b0;
          if (start) begin
            st            <= ST_LOAD;
            busy          <= 1'b1;
            overflow      <= 1'b0;
            region_active <= sel;
          end
        end
        ST_LOAD: begin
          if (fall) st <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (empty && req_idle) begin
            st            <= ST_IDLE;
            busy          <= 1'b0;
            done          <= 1'b1;
            region_active <= '0;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rom_loader.sv
module tb_rom_loader;
  logic       clk;
  logic       reset;
  logic       busy, done, overflow;
  logic [3:0] region_active;
  logic       busy_s, done_s, overflow_s;
  logic [3:0] region_active_s;

  rom_loader_if #(.DW(16), .AW(25)) bus ();
  rom_loader_if #(.DW(16), .AW(25)) bus_s ();

  rom_loader #(.NUM_REGIONS(4), .DW(16), .AW(25), .FIFO_DEPTH(4), .SWAP_BYTES(0)) dut (
    .clk_sys(clk), .reset(reset), .bus(bus), .busy(busy), .done(done),
    .region_active(region_active), .overflow(overflow));

  rom_loader #(.NUM_REGIONS(4), .DW(16), .AW(25), .FIFO_DEPTH(4), .SWAP_BYTES(1)) dut_s (
    .clk_sys(clk), .reset(reset), .bus(bus_s), .busy(busy_s), .done(done_s),
    .region_active(region_active_s), .overflow(overflow_s));

  // Byte-swapping instance sees the same ioctl stream, with a fast ack echo.
  assign bus_s.ioctl_download = bus.ioctl_download;
  assign bus_s.ioctl_index    = bus.ioctl_index;
  assign bus_s.ioctl_wr       = bus.ioctl_wr;
  assign bus_s.ioctl_addr     = bus.ioctl_addr;
  assign bus_s.ioctl_dout     = bus.ioctl_dout;
  always @(posedge clk) bus_s.mem_ack <= bus_s.mem_req;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Region table as the loader is expected to decode it.
  localparam int          TB_IDX  [4] = '{0, 1, 2, 3};
  localparam logic [24:0] TB_BASE [4] = '{25'h000000, 25'h100000, 25'h200000, 25'h300000};
  localparam logic [24:0] TB_SIZE [4] = '{25'h100000, 25'h000010, 25'h100000, 25'h001000};

  typedef struct {
    logic [24:0] addr;
    logic [15:0] data;
  } ent_t;

  ent_t exp_q[$];
  int   cur = -1;
  bit   exp_ovf = 0;
  bit   saw_wait = 0;
  int   n_chk = 0, n_fail = 0;
  int   n_toggle = 0, done_cnt = 0;
  int   ack_dly = 3;
  bit   ack_force = 0;
  logic ack_force_val = 1'b0;

  // SDRAM controller: echo mem_req onto mem_ack ack_dly cycles after it toggles.
  initial begin
    int pend;
    pend = 0;
    bus.mem_ack = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (ack_force) begin
        bus.mem_ack = ack_force_val;
        pend = 0;
      end else if (bus.mem_req !== bus.mem_ack) begin
        pend++;
        if (pend >= ack_dly) begin
          bus.mem_ack = bus.mem_req;
          pend = 0;
        end
      end else begin
        pend = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired, got no event, expected one", name);
  endtask

  // Every cycle: each new request must match the next expected write, and a
  // pending request must keep its address/data.
  task automatic monitor();
    logic        prev_req;
    logic [24:0] h_addr;
    logic [15:0] h_din;
    ent_t        e;
    prev_req = bus.mem_req;
    h_addr   = '0;
    h_din    = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = bus.mem_req;
        h_addr   = bus.mem_addr;
        h_din    = bus.mem_din;
        continue;
      end
      if (done) begin
        done_cnt++;
        check("done_at_idle", {27'd0, busy, region_active}, 32'd0);
      end
      if (bus.mem_req !== prev_req) begin
        n_toggle++;
        if (exp_q.size() == 0) begin
          check("unexpected_req_addr", {7'd0, bus.mem_addr}, 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          check("req_addr", {7'd0, bus.mem_addr}, {7'd0, e.addr});
          check("req_data", {16'd0, bus.mem_din}, {16'd0, e.data});
        end
        h_addr = bus.mem_addr;
        h_din  = bus.mem_din;
      end else if (bus.mem_req !== bus.mem_ack) begin
        check("hold_addr", {7'd0, bus.mem_addr}, {7'd0, h_addr});
        check("hold_data", {16'd0, bus.mem_din}, {16'd0, h_din});
      end
      prev_req = bus.mem_req;
    end
  endtask

  task automatic start_load(input logic [7:0] idx);
    bit got;
    bus.ioctl_index    = idx;
    bus.ioctl_download = 1'b1;
    cur = -1;
    for (int i = 3; i >= 0; i--) if (TB_IDX[i] == int'(idx[5:0])) cur = i;
    if (cur >= 0) begin
      exp_ovf = 0;
      got = 0;
      for (int n = 0; n < 500; n++) begin
        @(posedge clk); #1;
        if (region_active == 4'(1 << cur)) begin
          got = 1;
          break;
        end
      end
      if (!got) fail_now("start_load");
    end else begin
      repeat (3) begin @(posedge clk); #1; end
    end
  endtask

  task automatic end_load();
    bit got;
    bus.ioctl_download = 1'b0;
    got = 0;
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk); #1;
      if (!busy) begin
        got = 1;
        break;
      end
    end
    if (!got) fail_now("end_load");
    @(negedge clk);
    @(posedge clk); #1;
    cur = -1;
  endtask

  task automatic do_write(input logic [24:0] addr, input logic [15:0] data);
    bit   got;
    ent_t e;
    got = 1;
    for (int n = 0; bus.ioctl_wait; n++) begin
      saw_wait = 1;
      if (n >= 2000) begin
        got = 0;
        break;
      end
      @(posedge clk); #1;
    end
    if (!got) fail_now("ioctl_wait_release");
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = addr;
    bus.ioctl_dout = data;
    if (cur >= 0) begin
      if (addr < TB_SIZE[cur]) begin
        e.addr = TB_BASE[cur] + addr;
        e.data = data;
        exp_q.push_back(e);
      end else begin
        exp_ovf = 1;
      end
    end
    @(posedge clk); #1;
    bus.ioctl_wr = 1'b0;
  endtask

  initial begin
    int t0, d0;
    reset              = 1'b1;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    fork monitor(); join_none
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Reset state
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_overflow", {31'd0, overflow}, 0);
    check("rst_region", {28'd0, region_active}, 0);
    check("rst_wait", {31'd0, bus.ioctl_wait}, 0);
    check("rst_mem_addr", {7'd0, bus.mem_addr}, 0);
    check("rst_mem_din", {16'd0, bus.mem_din}, 0);
    check("rst_mem_req", {31'd0, bus.mem_req}, 0);

    // Region 1 load, 8 words, ack after 3 cycles (index bits 7:6 ignored)
    ack_dly = 3; t0 = n_toggle; d0 = done_cnt;
    start_load(8'h41);
    check("t1_region", {28'd0, region_active}, 32'b0010);
    check("t1_busy", {31'd0, busy}, 1);
    for (int i = 0; i < 8; i++) do_write(25'(2*i), 16'hA000 + 16'(i));
    end_load();
    check("t1_toggles", n_toggle - t0, 8);
    check("t1_done", done_cnt - d0, 1);
    check("t1_queue", exp_q.size(), 0);
    check("t1_overflow", {31'd0, overflow}, 0);
    check("t1_last_addr", {7'd0, bus.mem_addr}, 32'h10000E);
    check("t1_last_din", {16'd0, bus.mem_din}, 32'hA007);
    check("t1_region_idle", {28'd0, region_active}, 0);

    // Out-of-range write at offset 0x10 in a 0x10-byte region
    t0 = n_toggle; d0 = done_cnt;
    start_load(8'hC1);
    for (int i = 0; i < 8; i++) do_write(25'(2*i), 16'hB000 + 16'(i));
    do_write(25'h10, 16'hBEEF);
    @(posedge clk); #1;
    check("t2_overflow", {31'd0, overflow}, 1);
    check("t2_overflow_model", {31'd0, overflow}, {31'd0, exp_ovf});
    end_load();
    check("t2_toggles", n_toggle - t0, 8);
    check("t2_done", done_cnt - d0, 1);
    check("t2_queue", exp_q.size(), 0);
    check("t2_overflow_sticky", {31'd0, overflow}, 1);

    // Slow ack, back-to-back writes: flow control must prevent any drop
    ack_dly = 20; saw_wait = 0; t0 = n_toggle; d0 = done_cnt;
    start_load(8'h00);
    check("t3_overflow_cleared", {31'd0, overflow}, 0);
    for (int i = 0; i < 12; i++) do_write(25'h40 + 25'(2*i), 16'hC000 + 16'(i));
    check("t3_saw_wait", {31'd0, saw_wait}, 1);
    check("t3_overflow", {31'd0, overflow}, 0);
    end_load();
    check("t3_toggles", n_toggle - t0, 12);
    check("t3_done", done_cnt - d0, 1);
    check("t3_queue", exp_q.size(), 0);
    check("t3_last_addr", {7'd0, bus.mem_addr}, 32'h56);

    // Unknown index 0x2A: nothing happens
    ack_dly = 3; t0 = n_toggle; d0 = done_cnt;
    start_load(8'h2A);
    check("t4_busy", {31'd0, busy}, 0);
    for (int i = 0; i < 3; i++) do_write(25'(2*i), 16'hD000 + 16'(i));
    check("t4_busy_after", {31'd0, busy}, 0);
    check("t4_region", {28'd0, region_active}, 0);
    end_load();
    repeat (10) begin @(posedge clk); #1; end
    check("t4_toggles", n_toggle - t0, 0);
    check("t4_done", done_cnt - d0, 0);
    check("t4_overflow", {31'd0, overflow}, 0);

    // New download requested while the previous one is still draining
    ack_dly = 20; t0 = n_toggle; d0 = done_cnt;
    start_load(8'h02);
    for (int i = 0; i < 3; i++) do_write(25'(2*i), 16'hE000 + 16'(i));
    bus.ioctl_download = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t5_draining", {31'd0, busy}, 1);
    start_load(8'h03);
    check("t5_done_first", done_cnt - d0, 1);
    check("t5_busy", {31'd0, busy}, 1);
    check("t5_region", {28'd0, region_active}, 32'b1000);
    do_write(25'h20, 16'hE100);
    do_write(25'h22, 16'hE101);
    end_load();
    check("t5_toggles", n_toggle - t0, 5);
    check("t5_done", done_cnt - d0, 2);
    check("t5_queue", exp_q.size(), 0);
    check("t5_last_addr", {7'd0, bus.mem_addr}, 32'h300022);

    // Byte swap on the second instance
    ack_dly = 3;
    start_load(8'h01);
    do_write(25'h4, 16'h1234);
    end_load();
    check("t6_swap_din", {16'd0, bus_s.mem_din}, 32'h3412);
    check("t6_swap_addr", {7'd0, bus_s.mem_addr}, 32'h100004);
    check("t6_noswap_din", {16'd0, bus.mem_din}, 32'h1234);
    check("t6_swap_status", {22'd0, busy_s, done_s, overflow_s, region_active_s}, 0);

    // Reset with mem_ack=1, three buffered entries and one request in flight
    ack_force_val = 1'b1; ack_force = 1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
    check("t7_req_seed", {31'd0, bus.mem_req}, 1);
    t0 = n_toggle;
    start_load(8'h00);
    for (int i = 0; i < 4; i++) do_write(25'(2*i), 16'hF000 + 16'(i));
    repeat (2) begin @(posedge clk); #1; end
    check("t7_wait_three_buffered", {31'd0, bus.ioctl_wait}, 1);
    check("t7_one_issued", n_toggle - t0, 1);
    check("t7_req_pending", {31'd0, bus.mem_req}, 0);
    reset = 1'b1;
    exp_q.delete();
    cur = -1;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
    d0 = done_cnt; t0 = n_toggle;
    check("t7_req_after_reset", {31'd0, bus.mem_req}, 1);
    check("t7_wait_after_reset", {31'd0, bus.ioctl_wait}, 0);
    check("t7_busy_after_reset", {31'd0, busy}, 0);
    check("t7_region_after_reset", {28'd0, region_active}, 0);
    ack_force = 0;
    repeat (20) begin @(posedge clk); #1; end
    bus.ioctl_download = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check("t7_no_issue", n_toggle - t0, 0);
    check("t7_no_done", done_cnt - d0, 0);
    check("t7_idle", {31'd0, busy}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 NUM_REGIONS, 4, number of download regions decoded from ioctl_index.
REQ-002 DW, 16, ioctl/SDRAM data width in bits (8 or 16).
REQ-003 AW, 25, SDRAM byte-address width.
REQ-004 FIFO_DEPTH, 4, write-buffer entries (power of two, >=2).
REQ-005 SWAP_BYTES, 0, when 1 and DW=16, swap the two bytes of each word before buffering.
REQ-006 clk_sys  in  1  sole clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 ioctl_download  in  1  HPS download active.
REQ-009 ioctl_index  in  8  download index; bits [5:0] select the region.
REQ-010 ioctl_wr  in  1  one-cycle write strobe.
REQ-011 ioctl_addr  in  25  byte offset within the file.
REQ-012 ioctl_dout  in  DW  write data.
REQ-013 ioctl_wait  out  1  flow-control stall to hps_io.
REQ-014 mem_addr  out  AW  SDRAM write byte address.
REQ-015 mem_din  out  DW  SDRAM write data.
REQ-016 mem_req  out  1  toggle request; a request is pending while mem_req != mem_ack.
REQ-017 mem_ack  in  1  toggle acknowledge from the sdram controller.
REQ-018 busy  out  1  high in LOAD or DRAIN.
REQ-019 done  out  1  one-cycle pulse when a load finishes.
REQ-020 region_active  out  NUM_REGIONS  one-hot active region; all zero in IDLE.
REQ-021 overflow  out  1  sticky error flag; cleared only by reset or the start of a new load.

Function
REQ-022 FSM states: IDLE, LOAD, DRAIN.
REQ-023 IDLE->LOAD on a rising edge of ioctl_download where ioctl_index[5:0] equals REGION_TABLE[i].index for some i; the lowest matching i wins.
REQ-024 On IDLE->LOAD, latch base = REGION_TABLE[i].base and size = REGION_TABLE[i].size, clear overflow, and set region_active bit i.
REQ-025 A rising edge with no matching index leaves the FSM in IDLE, and all writes during that download are ignored without raising overflow.
REQ-026 In LOAD, each ioctl_wr pushes {base + ioctl_addr, data} into the FIFO in the same cycle; the entry is visible at the FIFO head on the next cycle.
REQ-027 A write is dropped and overflow is set if ioctl_addr >= size or the FIFO is full.
REQ-028 ioctl_wait is registered; it is 1 in the cycle after the FIFO count reaches >= FIFO_DEPTH-1 and 0 once the count is <= FIFO_DEPTH-2. This leaves room for one write already in flight.
REQ-029 Issue rule: when mem_req == mem_ack and the FIFO is non-empty, pop the head, register mem_addr/mem_din, and toggle mem_req in the same cycle. At most one request is outstanding.
REQ-030 mem_addr and mem_din hold stable until the matching ack arrives.
REQ-031 A push and a pop in the same cycle leave the FIFO count unchanged, and the push succeeds even when the FIFO is full.
REQ-032 LOAD->DRAIN on a falling edge of ioctl_download.
REQ-033 DRAIN->IDLE when the FIFO is empty and mem_req == mem_ack; done pulses in the cycle IDLE is entered and region_active clears at the same time.
REQ-034 A rising edge of ioctl_download during DRAIN is held pending and acted on in the first IDLE cycle.
REQ-035 Address arithmetic is modulo 2^AW, and ioctl_addr is zero-extended or truncated to AW.

Reset
REQ-036 Reset values: FSM = IDLE, FIFO empty, ioctl_wait 0, busy 0, done 0, overflow 0, region_active 0, mem_addr 0, mem_din 0.
REQ-037 On reset, mem_req is loaded with the current mem_ack so that no spurious request is issued.
REQ-038 Reset mid-load abandons the load: buffered entries are discarded, any outstanding request completes unobserved, and done is not pulsed.

Structure
REQ-039 Package loader_pkg defines region_t {index[5:0], base[AW-1:0], size[AW-1:0]}, the REGION_TABLE constant array, and the FSM state enum.
REQ-040 The FIFO is one sub-module, loader_fifo (parameters: width, depth; ports: push, pop, full, empty, count), with synchronous reset.

Verification
REQ-041 Region 1 (index 1, base 0x100000) loads 8 words at offsets 0..14 with mem_ack echoing after 3 cycles -> 8 toggles at 0x100000..0x10000E with matching data, one done pulse, overflow 0.
REQ-042 mem_ack is delayed 20 cycles while hps_io writes every cycle -> ioctl_wait rises before the FIFO fills, no write is dropped, and overflow stays 0.
REQ-043 Region size is 0x10 and a write lands at offset 0x10 -> that write is dropped, overflow=1, the prior 8 writes complete, and done pulses.
REQ-044 A download uses index 0x2A, which has no matching region -> no mem_req toggle, busy stays 0, no done pulse.
REQ-045 Reset is asserted with 3 FIFO entries and one request outstanding, with mem_ack=1 -> after reset mem_req=1, the FIFO is empty, and there is no done pulse.
REQ-046 With SWAP_BYTES=1, ioctl_dout=0x1234 is written -> mem_din=0x3412.
